ami_w: RTL and testbench
========================

Name: ami_w

Overview:
- AXI4 master write interface: the initiator-side counterpart of the slave write interface.
- User logic issues write commands and a plain data beat stream; the block drives the AXI AW, W and B channels.
- Generates WLAST from the command length and tracks outstanding bursts up to MST_OD.
- Single clock domain, no CDC. AXI widths (AXI_IW, AXI_AW, AXI_LW, AXI_SW, AXI_BURSTW, AXI_DW, AXI_WSTRBW, AXI_BRESPW) come from asi_pkg.

Parameters:
MST_OD, 4, max outstanding write bursts (commands accepted minus user-side responses consumed); power of 2, >=2; also depth of internal length queue

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
u_awid  in  AXI_IW  command id
u_awaddr  in  AXI_AW  command start address
u_awlen  in  AXI_LW  beats-1
u_awsize  in  AXI_SW  beat size
u_awburst  in  AXI_BURSTW  burst type, forwarded unchanged
u_awvalid  in  1  command valid
u_awready  out  1  command accepted when valid&ready
u_wdata  in  AXI_DW  beat data
u_wstrb  in  AXI_WSTRBW  beat strobes
u_wvalid  in  1  beat valid
u_wready  out  1  beat accepted when valid&ready
u_bid  out  AXI_IW  response id
u_bresp  out  AXI_BRESPW  response code
u_bvalid  out  1  response valid
u_bready  in  1  response consumed
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  AXI widths  AXI AW payload, registered
AWVALID  out  1 ; AWREADY  in  1
WDATA  out  AXI_DW ; WSTRB  out  AXI_WSTRBW ; WLAST  out  1
WVALID  out  1 ; WREADY  in  1
BID  in  AXI_IW ; BRESP  in  AXI_BRESPW ; BVALID  in  1 ; BREADY  out  1

Behaviour:
- Reset (ARESET high at ACLK edge): AWVALID=0, WVALID=0, u_wready=0, u_bvalid=0, outstanding count=0, length queue empty, W FSM=W_IDLE, AW payload regs=0, u_bid/u_bresp=0. u_awready is 0 while ARESET is high and 1 the cycle after. Mid-burst reset abandons the burst: no WLAST is emitted and no B response is produced.
- AW path:
  - u_awready = ~AWVALID | AWREADY, AND outstanding<MST_OD, AND length queue not full.
  - On accept, the payload is registered; AWVALID=1 next cycle (1-cycle latency).
  - Payload is held stable while AWVALID & ~AWREADY.
  - Back-to-back: an accept in the same cycle as AWREADY reloads the registers and AWVALID stays 1.
- On accept, u_awlen is pushed to the length queue (depth MST_OD) and outstanding increments.
- W FSM, states W_IDLE and W_DATA:
  - W_IDLE: if queue non-empty, pop, beat_cnt<=popped len, go W_DATA.
  - W_DATA: WVALID=u_wvalid; u_wready=WREADY; WDATA/WSTRB=u_wdata/u_wstrb combinational pass-through; WLAST=(beat_cnt==0).
  - On a W handshake with beat_cnt!=0: beat_cnt decrements.
  - On a W handshake with WLAST: if queue non-empty, pop and stay W_DATA (no bubble); else go W_IDLE.
  - In W_IDLE: WVALID=0, u_wready=0.
  - Queue pop and push in the same cycle are both honoured. A command accepted while the queue is empty and the FSM is idle reaches W_DATA 2 cycles after accept.
- W beats may reach AXI before the matching AW handshake; this is AXI-legal.
- B path:
  - One-entry holding register. BREADY = ~u_bvalid | u_bready.
  - On BVALID&BREADY: capture BID/BRESP into u_bid/u_bresp; u_bvalid=1 next cycle.
  - u_bvalid clears on u_bready unless refilled in the same cycle.
- Outstanding count:
  - +1 on user command accept; -1 on u_bvalid&u_bready; unchanged when both occur in the same cycle.
  - Width $clog2(MST_OD)+1; never exceeds MST_OD.
  - A B response arriving with count 0 is still forwarded; the count saturates at 0.
- No address arithmetic or size checking: the slave reports size errors via BRESP=SLVERR, which is forwarded unchanged.

Test Plan:
- Single beat: u_awaddr=0x100, len=0, size=3, one data beat 0xA5A5; AWREADY, WREADY, BVALID all tied 1 -> AWVALID high 1 cycle after accept with AWADDR=0x100; one W beat with WLAST=1; u_bvalid with u_bresp=0.
- Burst of 4 (len=3) with WREADY toggling 1,0,1,0… -> exactly 4 W handshakes; WLAST only on the 4th; data order preserved; WVALID never asserted in W_IDLE.
- Outstanding limit, MST_OD=4, BVALID held 0: issue 5 commands -> u_awready=0 after 4 accepts; one response consumed -> 5th accepted the cycle after.
- Back-to-back bursts: len=1 then len=2 with continuous data, WREADY=1 -> 5 consecutive W beats with no bubble; WLAST on beats 2 and 5.
- Backpressure: AWREADY held 0 for 3 cycles -> AWVALID and payload stable throughout, u_awready=0. u_bready held 0 with BVALID=1 -> BREADY=0 after the first capture; BID=5, BRESP=2 arrives as u_bid=5, u_bresp=2.
- Reset mid-burst: assert ARESET after 2 of 4 beats -> next cycle AWVALID=0, WVALID=0, u_bvalid=0; a new len=0 command then completes normally.

Source files
------------

// File: rtl/ami_w.sv
// AXI4 master write interface: user command/beat stream to AXI AW/W/B channels.
// Generates WLAST from the command length and bounds outstanding bursts.
package asi_pkg;
    localparam int unsigned AXI_IW     = 4;
    localparam int unsigned AXI_AW     = 32;
    localparam int unsigned AXI_LW     = 8;
    localparam int unsigned AXI_SW     = 3;
    localparam int unsigned AXI_BURSTW = 2;
    localparam int unsigned AXI_DW     = 32;
    localparam int unsigned AXI_WSTRBW = AXI_DW / 8;
    localparam int unsigned AXI_BRESPW = 2;

    typedef struct packed {
        logic [AXI_IW-1:0]     id;
        logic [AXI_AW-1:0]     addr;
        logic [AXI_LW-1:0]     len;
        logic [AXI_SW-1:0]     size;
        logic [AXI_BURSTW-1:0] burst;
    } aw_t;
endpackage

module ami_w
    import asi_pkg::*;
#(
    parameter int unsigned MST_OD = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [AXI_IW-1:0]     u_awid,
    input  logic [AXI_AW-1:0]     u_awaddr,
    input  logic [AXI_LW-1:0]     u_awlen,
    input  logic [AXI_SW-1:0]     u_awsize,
    input  logic [AXI_BURSTW-1:0] u_awburst,
    input  logic                  u_awvalid,
    output logic                  u_awready,
    input  logic [AXI_DW-1:0]     u_wdata,
    input  logic [AXI_WSTRBW-1:0] u_wstrb,
    input  logic                  u_wvalid,
    output logic                  u_wready,
    output logic [AXI_IW-1:0]     u_bid,
    output logic [AXI_BRESPW-1:0] u_bresp,
    output logic                  u_bvalid,
    input  logic                  u_bready,
    output logic [AXI_IW-1:0]     AWID,
    output logic [AXI_AW-1:0]     AWADDR,
    output logic [AXI_LW-1:0]     AWLEN,
    output logic [AXI_SW-1:0]     AWSIZE,
    output logic [AXI_BURSTW-1:0] AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [AXI_DW-1:0]     WDATA,
    output logic [AXI_WSTRBW-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [AXI_IW-1:0]     BID,
    input  logic [AXI_BRESPW-1:0] BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);
    localparam int unsigned CW = $clog2(MST_OD) + 1;
    localparam int unsigned PW = $clog2(MST_OD);

    typedef enum logic {W_IDLE, W_DATA} w_state_t;

    aw_t               aw_q;
    logic              aw_vld_q;
    logic [CW-1:0]     od_cnt_q;
    logic [CW-1:0]     q_cnt_q;
    logic [PW-1:0]     q_wr_q;
    logic [PW-1:0]     q_rd_q;
    logic [AXI_LW-1:0] len_mem [MST_OD];
    w_state_t          w_state_q, w_state_d;
    logic [AXI_LW-1:0] beat_cnt_q, beat_cnt_d;
    logic              q_pop;
    logic              q_empty;
    logic              aw_acc;
    logic              b_hs;
    logic              b_take;

    assign u_awready = ~ARESET & (~aw_vld_q | AWREADY)
                     & (od_cnt_q < CW'(MST_OD)) & (q_cnt_q < CW'(MST_OD));
    assign aw_acc    = u_awvalid & u_awready;
    assign q_empty   = (q_cnt_q == '0);
    assign BREADY    = ~u_bvalid | u_bready;
    assign b_hs      = BVALID & BREADY;
    assign b_take    = u_bvalid & u_bready;

    assign AWID    = aw_q.id;
    assign AWADDR  = aw_q.addr;
    assign AWLEN   = aw_q.len;
    assign AWSIZE  = aw_q.size;
    assign AWBURST = aw_q.burst;
    assign AWVALID = aw_vld_q;

    // AW register slice; an accept during AWREADY reloads without a bubble
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_vld_q <= 1'b0;
            aw_q     <= '0;
        end else if (aw_acc) begin
            aw_vld_q <= 1'b1;
            aw_q     <= '{id: u_awid, addr: u_awaddr, len: u_awlen,
                          size: u_awsize, burst: u_awburst};
        end else if (AWREADY) begin
            aw_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_acc) begin
            len_mem[q_wr_q] <= u_awlen;
        end
    end

    // Length queue pointers; depth is a power of two so pointers wrap naturally
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            q_wr_q  <= '0;
            q_rd_q  <= '0;
            q_cnt_q <= '0;
        end else begin
            if (aw_acc) q_wr_q <= q_wr_q + PW'(1);
            if (q_pop)  q_rd_q <= q_rd_q + PW'(1);
            q_cnt_q <= q_cnt_q + CW'(aw_acc) - CW'(q_pop);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            beat_cnt_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // W sequencing: beat_cnt counts down remaining beats; last beat chains the next burst
    always_comb begin
        w_state_d  = w_state_q;
        beat_cnt_d = beat_cnt_q;
        q_pop      = 1'b0;
        WVALID     = 1'b0;
        u_wready   = 1'b0;
        WLAST      = 1'b0;
        WDATA      = u_wdata;
        WSTRB      = u_wstrb;
        case (w_state_q)
            W_IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    beat_cnt_d = len_mem[q_rd_q];
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                WVALID   = u_wvalid;
                u_wready = WREADY;
                WLAST    = (beat_cnt_q == '0);
                if (u_wvalid && WREADY) begin
                    if (beat_cnt_q != '0) begin
                        beat_cnt_d = beat_cnt_q - AXI_LW'(1);
                    end else if (!q_empty) begin
                        q_pop      = 1'b1;
                        beat_cnt_d = len_mem[q_rd_q];
                    end else begin
                        w_state_d = W_IDLE;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // One-entry B holding register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            u_bvalid <= 1'b0;
            u_bid    <= '0;
            u_bresp  <= '0;
        end else if (b_hs) begin
            u_bvalid <= 1'b1;
            u_bid    <= BID;
            u_bresp  <= BRESP;
        end else if (u_bready) begin
            u_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            od_cnt_q <= '0;
        end else begin
            case ({aw_acc, b_take})
                2'b10:   od_cnt_q <= od_cnt_q + CW'(1);
                2'b01:   if (od_cnt_q != '0) od_cnt_q <= od_cnt_q - CW'(1);
                default: od_cnt_q <= od_cnt_q;
            endcase
        end
    end
endmodule

// File: tb/tb_ami_w.sv
// Randomized bench for ami_w: user side, AXI slave side and a transaction-level model.
module tb_ami_w;
    import asi_pkg::*;

    localparam int unsigned OD = 4;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic [AXI_IW-1:0]     u_awid;
    logic [AXI_AW-1:0]     u_awaddr;
    logic [AXI_LW-1:0]     u_awlen;
    logic [AXI_SW-1:0]     u_awsize;
    logic [AXI_BURSTW-1:0] u_awburst;
    logic                  u_awvalid;
    logic                  u_awready;
    logic [AXI_DW-1:0]     u_wdata;
    logic [AXI_WSTRBW-1:0] u_wstrb;
    logic                  u_wvalid;
    logic                  u_wready;
    logic [AXI_IW-1:0]     u_bid;
    logic [AXI_BRESPW-1:0] u_bresp;
    logic                  u_bvalid;
    logic                  u_bready;
    logic [AXI_IW-1:0]     AWID;
    logic [AXI_AW-1:0]     AWADDR;
    logic [AXI_LW-1:0]     AWLEN;
    logic [AXI_SW-1:0]     AWSIZE;
    logic [AXI_BURSTW-1:0] AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [AXI_DW-1:0]     WDATA;
    logic [AXI_WSTRBW-1:0] WSTRB;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    logic [AXI_IW-1:0]     BID;
    logic [AXI_BRESPW-1:0] BRESP;
    logic                  BVALID;
    logic                  BREADY;

    ami_w #(.MST_OD(OD)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .u_awid(u_awid), .u_awaddr(u_awaddr), .u_awlen(u_awlen), .u_awsize(u_awsize),
        .u_awburst(u_awburst), .u_awvalid(u_awvalid), .u_awready(u_awready),
        .u_wdata(u_wdata), .u_wstrb(u_wstrb), .u_wvalid(u_wvalid), .u_wready(u_wready),
        .u_bid(u_bid), .u_bresp(u_bresp), .u_bvalid(u_bvalid), .u_bready(u_bready),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int len;
        int acc;
    } burst_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          rst_left;
    logic [63:0] exp_aw[$];
    logic [63:0] exp_b[$];
    burst_t      bq[$];
    int          beat_idx;
    int          od;
    int          aw_hs_n, wl_n, b_sent_n;
    int          p_awv, p_wv, p_awr, p_wr, p_bv, p_br;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_aw(input logic [AXI_IW-1:0] id, input logic [AXI_AW-1:0] a,
                                            input logic [AXI_LW-1:0] l, input logic [AXI_SW-1:0] s,
                                            input logic [AXI_BURSTW-1:0] b);
        return 64'({id, a, l, s, b});
    endfunction

    function automatic bit rnd(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic model_clear();
        exp_aw.delete();
        exp_b.delete();
        bq.delete();
        beat_idx = 0;
        od       = 0;
        aw_hs_n  = 0;
        wl_n     = 0;
        b_sent_n = 0;
    endtask

    // One clock: check at negedge, advance the model, drive next inputs after posedge
    task automatic step();
        bit exp_awv, exp_awr, active, exp_ubv;
        bit aw_acc, aw_hs, w_hs, b_take, b_hs, was_rst;
        int owed;
        aw_acc = 0; aw_hs = 0; w_hs = 0; b_take = 0; b_hs = 0;
        @(negedge ACLK);
        was_rst = ARESET;
        if (ARESET) begin
            check("u_awready_in_reset", 64'(u_awready), 64'(0));
            model_clear();
        end else begin
            exp_awv = exp_aw.size() != 0;
            check("awvalid", 64'(AWVALID), 64'(exp_awv));
            if (exp_awv) check("aw_payload", pack_aw(AWID, AWADDR, AWLEN, AWSIZE, AWBURST), exp_aw[0]);
            exp_awr = (!exp_awv || AWREADY) && (od < OD);
            check("u_awready", 64'(u_awready), 64'(exp_awr));

            active = (bq.size() != 0) && (bq[0].acc + 2 <= cyc);
            check("wvalid", 64'(WVALID), 64'(active && u_wvalid));
            check("u_wready", 64'(u_wready), 64'(active && WREADY));
            if (active && u_wvalid) begin
                check("wlast", 64'(WLAST), 64'(beat_idx == bq[0].len));
                check("wdata", 64'({WSTRB, WDATA}), 64'({u_wstrb, u_wdata}));
            end

            exp_ubv = exp_b.size() != 0;
            check("u_bvalid", 64'(u_bvalid), 64'(exp_ubv));
            if (exp_ubv) check("u_bid_bresp", 64'({u_bid, u_bresp}), exp_b[0]);
            check("bready", 64'(BREADY), 64'(!exp_ubv || u_bready));

            aw_acc = u_awvalid && exp_awr;
            aw_hs  = exp_awv && AWREADY;
            w_hs   = active && u_wvalid && WREADY;
            b_take = exp_ubv && u_bready;
            b_hs   = BVALID && (!exp_ubv || u_bready);

            if (aw_hs) begin
                void'(exp_aw.pop_front());
                aw_hs_n++;
            end
            if (aw_acc) begin
                exp_aw.push_back(pack_aw(u_awid, u_awaddr, u_awlen, u_awsize, u_awburst));
                bq.push_back('{len: int'(u_awlen), acc: cyc});
                od++;
            end
            if (w_hs) begin
                if (beat_idx == bq[0].len) begin
                    void'(bq.pop_front());
                    beat_idx = 0;
                    wl_n++;
                end else begin
                    beat_idx++;
                end
            end
            if (b_take) begin
                void'(exp_b.pop_front());
                if (od > 0) od--;
            end
            if (b_hs) begin
                exp_b.push_back(64'({BID, BRESP}));
                b_sent_n++;
            end
        end

        @(posedge ACLK);
        cyc++;
        #1;
        if (rst_left > 0) begin
            ARESET = 1'b1;
            rst_left--;
        end else begin
            ARESET = 1'b0;
        end
        if (aw_acc || !u_awvalid || was_rst) begin
            u_awvalid = rnd(p_awv);
            u_awid    = AXI_IW'($urandom);
            u_awaddr  = $urandom;
            u_awlen   = AXI_LW'($urandom_range(0, 5));
            u_awsize  = AXI_SW'($urandom);
            u_awburst = AXI_BURSTW'($urandom);
        end
        if (w_hs || !u_wvalid || was_rst) begin
            u_wvalid = rnd(p_wv);
            u_wdata  = $urandom;
            u_wstrb  = AXI_WSTRBW'($urandom);
        end
        AWREADY  = rnd(p_awr);
        WREADY   = rnd(p_wr);
        u_bready = rnd(p_br);
        if (b_hs || !BVALID || was_rst) begin
            owed   = ((aw_hs_n < wl_n) ? aw_hs_n : wl_n) - b_sent_n;
            BVALID = (owed > 0) && rnd(p_bv);
            BID    = AXI_IW'($urandom);
            BRESP  = AXI_BRESPW'($urandom);
        end
    endtask

    int phases [6][6] = '{
        '{100, 100, 100, 100, 100, 100},
        '{ 60,  80,  50,  50,  60,  60},
        '{ 80,  90, 100, 100,   0, 100},
        '{ 70,  70,  30,  70,  80,  20},
        '{ 50,  50,  50,  50,  50,  50},
        '{ 90,  90,  90,  90,  90,  90}
    };

    initial begin
        ARESET = 1'b1;
        u_awvalid = 1'b0; u_awid = '0; u_awaddr = '0; u_awlen = '0; u_awsize = '0; u_awburst = '0;
        u_wvalid = 1'b0; u_wdata = '0; u_wstrb = '0; u_bready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BID = '0; BRESP = '0;
        p_awv = 0; p_wv = 0; p_awr = 0; p_wr = 0; p_bv = 0; p_br = 0;
        rst_left = 2;
        model_clear();
        for (int k = 0; k < 3; k++) step();

        for (int p = 0; p < 6; p++) begin
            p_awv = phases[p][0]; p_wv = phases[p][1]; p_awr = phases[p][2];
            p_wr  = phases[p][3]; p_bv = phases[p][4]; p_br  = phases[p][5];
            for (int c = 0; c < 500; c++) begin
                if (p == 4 && (c == 137 || c == 311)) rst_left = 1;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
